// File: rtl/timer_responder.sv
// Memory-mapped countdown timer on the peripheral bus. The bridge supplies the
// word offset, write strobe and write data. The block returns read data and
// raises an interrupt request to CP0 when the count expires.
module timer_responder #(
  parameter int CTRL_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_preset;
  logic [31:0]       r_count;
  logic [31:0]       w_count_next;
  logic              r_irq_flag;

  logic              w_ctrl_wr;
  logic              w_preset_wr;
  logic              w_enable;
  logic [1:0]        w_mode;
  logic              w_fsm_set_flag;
  logic              w_fsm_clr_flag;
  logic              w_fsm_disable;

  assign w_ctrl_wr   = we && (addr == 2'd0);
  assign w_preset_wr = we && (addr == 2'd1);
  assign w_enable    = r_ctrl[0];
  assign w_mode      = r_ctrl[2:1];
  assign irq         = r_irq_flag & r_ctrl[3];

  // Next-state and count logic; the flag and Enable side effects are exported as strobes
  always_comb begin
    w_next_state   = r_state;
    w_count_next   = r_count;
    w_fsm_set_flag = 1'b0;
    w_fsm_clr_flag = 1'b0;
    w_fsm_disable  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enable) begin
          w_fsm_clr_flag = 1'b1;
          w_next_state   = LOAD;
        end
      end
      LOAD: begin
        w_count_next = r_preset;
        w_next_state = CNT;
      end
      CNT: begin
        if (!w_enable) begin
          w_next_state = IDLE;
        end else if (r_count > 32'd1) begin
          w_count_next = r_count - 32'd1;
        end else begin
          w_count_next = 32'd0;
          w_next_state = INT;
        end
      end
      INT: begin
        w_fsm_set_flag = 1'b1;
        w_next_state   = IDLE;
        if (w_mode != 2'b01) begin
          w_fsm_disable = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State and COUNT registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_next;
    end
  end

  // CTRL register: a CPU write beats the one-shot auto-disable in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
    end else if (w_ctrl_wr) begin
      r_ctrl <= din[CTRL_W-1:0];
    end else if (w_fsm_disable) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  // PRESET register; only sampled by the FSM in LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_preset <= 32'd0;
    end else if (w_preset_wr) begin
      r_preset <= din;
    end
  end

  // Expiry flag: a CTRL write always clears it, otherwise expiry sets it and a restart clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_flag <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_irq_flag <= 1'b0;
    end else if (w_fsm_set_flag) begin
      r_irq_flag <= 1'b1;
    end else if (w_fsm_clr_flag) begin
      r_irq_flag <= 1'b0;
    end
  end

  // Combinational read mux; unimplemented CTRL bits and the reserved word read as zero
  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {{(32-CTRL_W){1'b0}}, r_ctrl};
      2'd1:    dout = r_preset;
      2'd2:    dout = r_count;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_responder.sv
// Directed testbench for timer_responder with hand-computed expectations.
module tb_timer_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  timer_responder #(.CTRL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a bus write from a falling edge; returns at the falling edge after the write edge
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we   = 1'b0;
    din  = 32'd0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'd0;

    // Reset state
    stepCycles(2);
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], rd);
      checkOutput("rst_dout", rd, 32'd0);
    end
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    stepCycles(1);

    // One-shot, PRESET=5
    applyStimulus(2'd1, 32'd5);
    applyStimulus(2'd0, 32'h9);
    stepCycles(2);
    readReg(2'd2, rd); checkOutput("os_count_e2", rd, 32'd5);
    stepCycles(4);
    readReg(2'd2, rd); checkOutput("os_count_e6", rd, 32'd1);
    checkOutput("os_irq_e6", {31'd0, irq}, 32'd0);
    stepCycles(1);
    checkOutput("os_irq_e7", {31'd0, irq}, 32'd0);
    stepCycles(1);
    checkOutput("os_irq_e8", {31'd0, irq}, 32'd1);
    readReg(2'd0, rd); checkOutput("os_ctrl", rd, 32'h8);
    readReg(2'd2, rd); checkOutput("os_count_end", rd, 32'd0);
    stepCycles(20);
    checkOutput("os_irq_hold", {31'd0, irq}, 32'd1);
    applyStimulus(2'd0, 32'h0);
    checkOutput("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: 1-cycle pulse every 6 cycles
    applyStimulus(2'd1, 32'd3);
    applyStimulus(2'd0, 32'hB);
    for (int k = 1; k <= 25; k++) begin
      stepCycles(1);
      checkOutput("ar_irq", {31'd0, irq}, (k % 6 == 0) ? 32'd1 : 32'd0);
      if (k % 6 == 0) begin
        readReg(2'd0, rd); checkOutput("ar_ctrl", rd, 32'hB);
      end
    end
    applyStimulus(2'd0, 32'h0);
    stepCycles(4);

    // Masked expiry, PRESET=4
    applyStimulus(2'd1, 32'd4);
    applyStimulus(2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      stepCycles(1);
      checkOutput("mask_irq", {31'd0, irq}, 32'd0);
    end
    readReg(2'd0, rd); checkOutput("mask_ctrl", rd, 32'h0);
    readReg(2'd2, rd); checkOutput("mask_count", rd, 32'd0);

    // Disable mid-count, PRESET=10
    applyStimulus(2'd1, 32'd10);
    applyStimulus(2'd0, 32'h9);
    stepCycles(5);
    readReg(2'd2, rd); checkOutput("dis_count7", rd, 32'd7);
    applyStimulus(2'd0, 32'h8);
    stepCycles(5);
    readReg(2'd2, rd); checkOutput("dis_frozen", rd, 32'd6);
    checkOutput("dis_irq", {31'd0, irq}, 32'd0);

    // Bus edges
    applyStimulus(2'd2, 32'hFFFF_FFFF);
    applyStimulus(2'd3, 32'hFFFF_FFFF);
    readReg(2'd2, rd); checkOutput("bus_count_ro", rd, 32'd6);
    readReg(2'd3, rd); checkOutput("bus_rsvd", rd, 32'd0);
    readReg(2'd1, rd); checkOutput("bus_preset", rd, 32'd10);
    applyStimulus(2'd0, 32'hFFFF_FFFF);
    readReg(2'd0, rd); checkOutput("bus_ctrl_f", rd, 32'hF);
    applyStimulus(2'd0, 32'h0);
    stepCycles(3);
    readReg(2'd2, rd); checkOutput("bus_count_ld", rd, 32'd10);
    readReg(2'd0, rd); checkOutput("bus_ctrl_0", rd, 32'h0);
    applyStimulus(2'd1, 32'd0);
    applyStimulus(2'd0, 32'h9);
    stepCycles(3);
    checkOutput("p0_irq_e3", {31'd0, irq}, 32'd0);
    stepCycles(1);
    checkOutput("p0_irq_e4", {31'd0, irq}, 32'd1);

    // Collision: CTRL write while FSM is in INT
    applyStimulus(2'd1, 32'd4);
    applyStimulus(2'd0, 32'h9);
    stepCycles(6);
    readReg(2'd2, rd); checkOutput("col_count_int", rd, 32'd0);
    applyStimulus(2'd0, 32'h9);
    readReg(2'd0, rd); checkOutput("col_ctrl", rd, 32'h9);
    checkOutput("col_irq", {31'd0, irq}, 32'd0);
    stepCycles(2);
    readReg(2'd2, rd); checkOutput("col_reload", rd, 32'd4);
    stepCycles(4);
    checkOutput("col_irq_w6", {31'd0, irq}, 32'd0);
    stepCycles(1);
    checkOutput("col_irq_w7", {31'd0, irq}, 32'd1);

    // Reset while irq is pending
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_pend_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count with COUNT=3
    applyStimulus(2'd1, 32'd5);
    applyStimulus(2'd0, 32'h9);
    stepCycles(4);
    readReg(2'd2, rd); checkOutput("rst_mid_pre", rd, 32'd3);
    #2 reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], rd);
      checkOutput("rst_mid_dout", rd, 32'd0);
    end
    checkOutput("rst_mid_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stepCycles(3);
    readReg(2'd2, rd); checkOutput("rst_post_count", rd, 32'd0);
    readReg(2'd0, rd); checkOutput("rst_post_ctrl", rd, 32'd0);
    checkOutput("rst_post_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
Memory-mapped programmable countdown timer that answers CPU bridge accesses in the peripheral window (0x7f00–0x7f0b for timer 0, 0x7f10–0x7f1b for timer 1; one instance per window).
It is the device end of the peripheral bus. The bridge decodes the window and presents the word offset, write enable and write data. The device returns read data that the CPU read-data mux forwards as peripheral read data.
It raises an interrupt request to CP0 when the count expires.

Parameters:
CTRL_W, 4, number of implemented CTRL bits; upper bits read as 0.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
addr  input  2  word offset within window (bus address bits [3:2])
we  input  1  write strobe, already qualified by the bridge window decode
din  input  32  write data
dout  output  32  read data, combinational on addr
irq  output  1  interrupt request to CP0

Behaviour:
- Register map by addr:
  - 0: CTRL. Bit [0] Enable, bits [2:1] Mode, bit [3] IM (interrupt mask).
  - 1: PRESET, read/write.
  - 2: COUNT, read-only.
  - 3: reserved, reads 0.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Outputs: irq=0, dout reflects the zeroed registers.
- Writes (we=1, rising edge):
  - addr 0: CTRL <= din[3:0]; also clears irq_flag.
  - addr 1: PRESET <= din.
  - addr 2/3: ignored, no side effect.
- Reads (combinational, no side effect):
  - addr 0: dout = {28'b0, CTRL}
  - addr 1: dout = PRESET
  - addr 2: dout = COUNT
  - addr 3: dout = 0
- irq = irq_flag & CTRL[3].
- FSM, one transition per edge:
  - IDLE: if Enable, clear irq_flag and go to LOAD; else stay and hold COUNT.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if !Enable, go to IDLE and freeze COUNT.
    - else if COUNT > 1, COUNT <= COUNT-1.
    - else (COUNT is 0 or 1), COUNT <= 0 and go to INT.
  - INT: irq_flag <= 1; go to IDLE.
    - Mode 00: Enable <= 0 (one-shot). irq stays high until CTRL is written.
    - Mode 01: Enable kept (auto-reload). The flag is cleared at the next edge by IDLE, giving a one-cycle irq pulse.
    - Modes 10/11 behave as 00.
- Latency, mode 0, PRESET=N≥1, CTRL write taken at edge E:
  - LOAD at E+1, COUNT=N at E+2.
  - COUNT=1 at E+N+1, INT at E+N+2.
  - irq high after E+N+3.
  - PRESET=0 behaves as N=1.
- Mode 1 period is N+3 cycles, with irq high for 1 cycle per period.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears Enable (INT, mode 0): the CPU write wins, including Enable, and irq_flag is cleared.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - A CTRL write with Enable=0 during LOAD or CNT: FSM goes to IDLE on the following edge, COUNT frozen at its value then.
- Reset mid-operation: immediate return to reset values regardless of FSM state. No pending irq survives reset.
- COUNT never underflows and never wraps.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle with COUNT=3 in CNT, irq=1 → dout at all addrs = 0 and irq=0 immediately; state IDLE after release.
2. One-shot: write PRESET=5, then CTRL=0x9 at edge E → COUNT reads 5 at E+2 and 1 at E+6; irq rises after E+8; CTRL reads 0x8; COUNT reads 0; irq stays 1 for 20 cycles; writing CTRL=0x0 drops irq on the next edge.
3. Auto-reload: PRESET=3, CTRL=0xB → irq is a 1-cycle pulse every 6 cycles across 4 periods; CTRL reads 0xB throughout.
4. Mask and disable: PRESET=4, CTRL=0x1 → irq never asserts while internal expiry occurs; then PRESET=10, CTRL=0x9, and write CTRL=0x8 when COUNT reads 7 → COUNT frozen at 6 or 7 per the 1-edge rule, no irq.
5. Bus edges: write 0xFFFFFFFF to addr 0, 2 and 3 → CTRL reads 0xF, COUNT unchanged, addr 3 reads 0; PRESET=0 with Enable gives irq after E+4.
6. Collision: in mode 0, write CTRL=0x9 in the exact cycle the FSM is in INT → Enable remains 1, irq_flag cleared, and a new count of PRESET starts.
